// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and decoded-bundle field widths shared by decoder and execute stage
package alu_pkg;
  localparam int OP_W = 4;
  localparam int REG_ID_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [OP_W-1:0] {
    OP_AND         = 4'b0000,
    OP_OR          = 4'b0001,
    OP_ADD         = 4'b0010,
    OP_SUB         = 4'b0110,
    OP_SLT         = 4'b0111,
    OP_NOR         = 4'b1100,
    OP_NOT_DEFINED = 4'b1111
  } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, zero, signed overflow and illegal-op flags
module alu_core
  import alu_pkg::*;
#(
  parameter int DWIDTH = DATA_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal
);
  logic [DWIDTH-1:0] sum, diff;
  assign sum = a + b;
  assign diff = a - b;
  always_comb begin
    result = '0;
    overflow = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_SLT: result = DWIDTH'($signed(a) < $signed(b));
      OP_ADD: begin
        result = sum;
        overflow = (a[DWIDTH-1] == b[DWIDTH-1]) && (sum[DWIDTH-1] != a[DWIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        overflow = (a[DWIDTH-1] != b[DWIDTH-1]) && (diff[DWIDTH-1] != a[DWIDTH-1]);
      end
      default: illegal = 1'b1;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage execute/writeback with register file, forwarding and valid/ready handshake
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DWIDTH = DATA_W,
  parameter int NREG = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     op,
  input  logic                ssel,
  input  logic [DWIDTH-1:0]   imm,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  input  logic [REG_ID_W-1:0] rdst_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   result,
  output logic [REG_ID_W-1:0] result_rd,
  output logic                zero,
  output logic                overflow,
  output logic                illegal,
  output logic [31:0]         retired,
  input  logic [REG_ID_W-1:0] dbg_id,
  output logic [DWIDTH-1:0]   dbg_data
);
  logic [DWIDTH-1:0] rf_q [NREG];
  logic [DWIDTH-1:0] rf_d [NREG];
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [OP_W-1:0] s1_op_q, s1_op_d;
  logic [REG_ID_W-1:0] s1_rd_q, s1_rd_d, result_rd_q, result_rd_d;
  logic [DWIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, result_q, result_d;
  logic zero_q, zero_d, overflow_q, overflow_d, illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;
  logic [DWIDTH-1:0] alu_res, opa, opb;
  logic alu_zero, alu_ovf, alu_ill;
  logic s2_free, s1_move, accept, wr_en;
  alu_core #(.DWIDTH(DWIDTH)) u_core (
    .op(s1_op_q),
    .a(s1_a_q),
    .b(s1_b_q),
    .result(alu_res),
    .zero(alu_zero),
    .overflow(alu_ovf),
    .illegal(alu_ill)
  );
  always_comb begin
    s2_free = !out_valid_q || out_ready;
    s1_move = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s1_move;
    accept = in_valid && in_ready;
    wr_en = s1_move && !alu_ill && s1_rd_q != '0;
    opa = rs1_id == '0 ? '0 : wr_en && s1_rd_q == rs1_id ? alu_res : rf_q[rs1_id];
    opb = rs2_id == '0 ? '0 : wr_en && s1_rd_q == rs2_id ? alu_res : rf_q[rs2_id];
    s1_valid_d = accept || (s1_valid_q && !s1_move);
    s1_op_d = accept ? op : s1_op_q;
    s1_rd_d = accept ? rdst_id : s1_rd_q;
    s1_a_d = accept ? opa : s1_a_q;
    s1_b_d = accept ? (ssel ? opb : imm) : s1_b_q;
    out_valid_d = s1_move || (out_valid_q && !out_ready);
    result_d = s1_move ? alu_res : result_q;
    result_rd_d = s1_move ? s1_rd_q : result_rd_q;
    zero_d = s1_move ? alu_zero : zero_q;
    overflow_d = s1_move ? alu_ovf : overflow_q;
    illegal_d = s1_move ? alu_ill : illegal_q;
    retired_d = retired_q + 32'(out_valid_q && out_ready);
    rf_d = rf_q;
    if (wr_en) rf_d[s1_rd_q] = alu_res;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q <= '0;
      s1_rd_q <= '0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      result_rd_q <= '0;
      zero_q <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q <= s1_op_d;
      s1_rd_q <= s1_rd_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      result_rd_q <= result_rd_d;
      zero_q <= zero_d;
      overflow_q <= overflow_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      rf_q <= rf_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign result_rd = result_rd_q;
  assign zero = zero_q;
  assign overflow = overflow_q;
  assign illegal = illegal_q;
  assign retired = retired_q;
  assign dbg_data = dbg_id == '0 ? '0 : rf_q[dbg_id];
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: table-driven scoreboard bench for the execute/writeback stage
module tb_alu_exec_stage;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, ssel, out_valid, out_ready, zero, overflow, illegal;
  logic [3:0] op;
  logic [31:0] imm, result, retired, dbg_data;
  logic [4:0] rs1_id, rs2_id, rdst_id, result_rd, dbg_id;
  typedef struct {
    logic [3:0] op;
    logic ssel;
    logic [31:0] imm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [31:0] res;
    logic ovf;
    logic ill;
  } vec_t;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0] rd;
    logic z;
    logic ovf;
    logic ill;
  } exp_t;
  exp_t q[$];
  logic [31:0] mdl [32];
  vec_t tbl [18];
  int checks = 0;
  int fails = 0;
  int tries;
  always #5 clk = ~clk;
  alu_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .ssel(ssel),
    .imm(imm), .rs1_id(rs1_id), .rs2_id(rs2_id), .rdst_id(rdst_id), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_rd(result_rd), .zero(zero),
    .overflow(overflow), .illegal(illegal), .retired(retired), .dbg_id(dbg_id), .dbg_data(dbg_data)
  );
  function automatic vec_t mk(input logic [3:0] o, input logic s, input logic [31:0] im,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                              input logic [31:0] r, input logic ov, input logic il);
    return '{o, s, im, a, b, d, r, ov, il};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic mon();
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", {31'b0, out_valid}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("result_rd", {27'b0, result_rd}, {27'b0, e.rd});
        chk("zero", {31'b0, zero}, {31'b0, e.z});
        chk("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t v);
    op = v.op;
    ssel = v.ssel;
    imm = v.imm;
    rs1_id = v.rs1;
    rs2_id = v.rs2;
    rdst_id = v.rd;
    in_valid = 1'b1;
  endtask
  task automatic send(input vec_t v, output int n);
    logic ok;
    ok = 1'b0;
    n = 0;
    drive(v);
    while (!ok && n < 30) begin
      @(negedge clk);
      mon();
      ok = in_ready;
      n++;
      if (ok) begin
        q.push_back('{v.res, v.rd, v.res == 32'd0, v.ovf, v.ill});
        if (!v.ill && v.rd != 5'd0) mdl[v.rd] = v.res;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 40 && q.size() != 0; n++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    foreach (mdl[i]) mdl[i] = 32'd0;
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_id = 5'(i);
      #1;
      chk($sformatf("%s_x%0d", tag, i), dbg_data, mdl[i]);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 4'd0;
    ssel = 1'b0;
    imm = 32'd0;
    rs1_id = 5'd0;
    rs2_id = 5'd0;
    rdst_id = 5'd0;
    dbg_id = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_result_rd", {27'b0, result_rd}, 32'd0);
    chk("rst_flags", {29'b0, zero, overflow, illegal}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    tbl[0]  = mk(OP_ADD, 1'b0, 32'd5,        5'd0,  5'd0, 5'd1,  32'd5,        1'b0, 1'b0);
    tbl[1]  = mk(OP_ADD, 1'b0, 32'd7,        5'd0,  5'd0, 5'd1,  32'd7,        1'b0, 1'b0);
    tbl[2]  = mk(OP_SUB, 1'b1, 32'd0,        5'd1,  5'd1, 5'd2,  32'd0,        1'b0, 1'b0);
    tbl[3]  = mk(OP_SLT, 1'b1, 32'd0,        5'd0,  5'd1, 5'd3,  32'd1,        1'b0, 1'b0);
    tbl[4]  = mk(OP_NOR, 1'b0, 32'h80000000, 5'd0,  5'd0, 5'd1,  32'h7FFFFFFF, 1'b0, 1'b0);
    tbl[5]  = mk(OP_ADD, 1'b1, 32'd0,        5'd1,  5'd1, 5'd2,  32'hFFFFFFFE, 1'b1, 1'b0);
    tbl[6]  = mk(OP_ADD, 1'b0, 32'h80000000, 5'd0,  5'd0, 5'd5,  32'h80000000, 1'b0, 1'b0);
    tbl[7]  = mk(OP_SLT, 1'b0, 32'd1,        5'd5,  5'd0, 5'd6,  32'd1,        1'b0, 1'b0);
    tbl[8]  = mk(OP_SUB, 1'b0, 32'd1,        5'd5,  5'd0, 5'd7,  32'h7FFFFFFF, 1'b1, 1'b0);
    tbl[9]  = mk(OP_AND, 1'b0, 32'hF0F0F0F0, 5'd1,  5'd0, 5'd8,  32'h70F0F0F0, 1'b0, 1'b0);
    tbl[10] = mk(OP_OR,  1'b0, 32'h0000000F, 5'd8,  5'd0, 5'd9,  32'h70F0F0FF, 1'b0, 1'b0);
    tbl[11] = mk(OP_ADD, 1'b0, 32'h55,       5'd0,  5'd0, 5'd4,  32'h55,       1'b0, 1'b0);
    tbl[12] = mk(4'b0011, 1'b0, 32'd5,       5'd1,  5'd0, 5'd4,  32'd0,        1'b0, 1'b1);
    tbl[13] = mk(OP_NOT_DEFINED, 1'b1, 32'd0, 5'd1, 5'd1, 5'd4,  32'd0,        1'b0, 1'b1);
    tbl[14] = mk(OP_ADD, 1'b0, 32'd0,        5'd4,  5'd0, 5'd11, 32'h55,       1'b0, 1'b0);
    tbl[15] = mk(OP_ADD, 1'b0, 32'd9,        5'd0,  5'd0, 5'd0,  32'd9,        1'b0, 1'b0);
    tbl[16] = mk(OP_ADD, 1'b1, 32'd0,        5'd0,  5'd0, 5'd10, 32'd0,        1'b0, 1'b0);
    tbl[17] = mk(OP_SUB, 1'b0, 32'hFFFFFFFF, 5'd7,  5'd0, 5'd12, 32'h80000000, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      send(tbl[i], tries);
      chk($sformatf("in_ready_first_try_%0d", i), 32'(tries), 32'd1);
    end
    drain();
    chk("retired_table", retired, 32'd18);
    sweep("rf");
    reset_dut();
    out_ready = 1'b0;
    send(mk(OP_ADD, 1'b0, 32'd1, 5'd0, 5'd0, 5'd13, 32'd1, 1'b0, 1'b0), tries);
    send(mk(OP_ADD, 1'b0, 32'd2, 5'd13, 5'd0, 5'd14, 32'd3, 1'b0, 1'b0), tries);
    chk("bp_second_accept", 32'(tries), 32'd1);
    drive(mk(OP_ADD, 1'b1, 32'd0, 5'd14, 5'd13, 5'd15, 32'd4, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp_out_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_result_%0d", i), result, 32'd1);
      chk($sformatf("bp_result_rd_%0d", i), {27'b0, result_rd}, 32'd13);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(mk(OP_ADD, 1'b1, 32'd0, 5'd14, 5'd13, 5'd15, 32'd4, 1'b0, 1'b0), tries);
    chk("bp_release_accept", 32'(tries), 32'd1);
    drain();
    chk("bp_retired", retired, 32'd3);
    out_ready = 1'b0;
    send(mk(OP_ADD, 1'b0, 32'h1234, 5'd0, 5'd0, 5'd20, 32'h1234, 1'b0, 1'b0), tries);
    send(mk(OP_ADD, 1'b0, 32'h99, 5'd0, 5'd0, 5'd21, 32'h99, 1'b0, 1'b0), tries);
    chk("mid_s2_full", {31'b0, out_valid}, 32'd1);
    chk("mid_s1_full", {31'b0, in_ready}, 32'd0);
    reset_dut();
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_retired", retired, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_result", result, 32'd0);
    sweep("mid_rst");
    out_ready = 1'b1;
    send(mk(OP_ADD, 1'b0, 32'd3, 5'd0, 5'd0, 5'd1, 32'd3, 1'b0, 1'b0), tries);
    drain();
    chk("post_rst_retired", retired, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
